// File: rtl/voice_scheduler_pkg.sv
// Shared MIDI event types plus voice and scheduler state encodings.
// Imported by the note queue, the interface and the scheduler top.
package voice_scheduler_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } status_t;

  typedef logic [6:0] note_t;
  typedef logic [6:0] velocity_t;

  typedef struct packed {
    status_t   status;
    note_t     note_number;
    velocity_t velocity;
  } note_change_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RELEASING
  } voice_state_t;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_DECIDE,
    FSM_STEAL
  } fsm_state_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// Note input, overflow flag and per-voice command bus of the scheduler.
// slave faces the scheduler; master faces the parser/pipeline side.
interface voice_scheduler_if #(
  parameter int PIPELINE_COUNT = 4
);
  import voice_scheduler_pkg::*;

  note_change_t                       note;
  logic                               note_ready;
  logic                               overflow;
  logic         [PIPELINE_COUNT-1:0]  pipeline_released;
  note_change_t [PIPELINE_COUNT-1:0]  pipeline_notes;
  logic         [PIPELINE_COUNT-1:0]  pipeline_notes_ready;

  modport master (
    output note, note_ready, pipeline_released,
    input  overflow, pipeline_notes, pipeline_notes_ready
  );

  modport slave (
    input  note, note_ready, pipeline_released,
    output overflow, pipeline_notes, pipeline_notes_ready
  );

endinterface

// File: rtl/note_queue.sv
// First-word-fall-through FIFO of note events; a push is visible at head next cycle.
// Pushes while full are ignored (caller flags the drop); pops while empty are ignored.
module note_queue
  import voice_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          push,
  input  note_change_t                  push_data,
  input  logic                          pop,
  output note_change_t                  head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(QUEUE_DEPTH):0]  count
);
  localparam int AW = $clog2(QUEUE_DEPTH);

  note_change_t  mem_q [QUEUE_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty stay distinct.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW+1)'(QUEUE_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/voice_scheduler.sv
// Queues note events and assigns them to voices (retrigger, first idle, else LRU steal).
// Strobe two cycles after acceptance; a steal takes two cycles; full queue drops and flags overflow.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int PIPELINE_COUNT = 4,
  parameter int QUEUE_DEPTH    = 8
) (
  input logic               clock_50_000_000,
  input logic               reset_l,
  voice_scheduler_if.slave  bus
);
  localparam int VW = $clog2(PIPELINE_COUNT);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  typedef logic [VW-1:0] voice_t;

  fsm_state_t                         fsm_q, fsm_d;
  voice_state_t                       vstate_q [PIPELINE_COUNT];
  voice_state_t                       vstate_d [PIPELINE_COUNT];
  note_t                              vnote_q  [PIPELINE_COUNT];
  note_t                              vnote_d  [PIPELINE_COUNT];
  voice_t                             age_q    [PIPELINE_COUNT];
  voice_t                             age_d    [PIPELINE_COUNT];
  voice_t                             victim_q, victim_d;
  note_change_t [PIPELINE_COUNT-1:0]  notes_q, notes_d;
  logic         [PIPELINE_COUNT-1:0]  strobe_q, strobe_d;
  logic                               overflow_q, overflow_d;

  note_change_t    head;
  logic            q_full, q_empty, q_pop, push_acc;
  logic [CW-1:0]   q_count, next_count;
  logic            match_found, idle_found, rel_found, go_steal, touch_en;
  voice_t          match_v, idle_v, rel_v, act_v, rel_age, act_age, touch_v;

  note_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_note_queue (
    .clk       (clock_50_000_000),
    .rst_l     (reset_l),
    .push      (bus.note_ready),
    .push_data (bus.note),
    .pop       (q_pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign push_acc                 = bus.note_ready && !q_full;
  assign bus.pipeline_notes       = notes_q;
  assign bus.pipeline_notes_ready = strobe_q;
  assign bus.overflow             = overflow_q;

  // Downward scan leaves the lowest matching index; ages are unique so max-age needs no tiebreak.
  always_comb begin
    match_found = 1'b0;  match_v = '0;
    idle_found  = 1'b0;  idle_v  = '0;
    rel_found   = 1'b0;  rel_v   = '0;  rel_age = '0;
    act_v       = '0;    act_age = '0;
    for (int i = PIPELINE_COUNT - 1; i >= 0; i--) begin
      if (vstate_q[i] == ACTIVE && vnote_q[i] == head.note_number) begin
        match_found = 1'b1;
        match_v     = voice_t'(i);
      end
      if (vstate_q[i] == IDLE) begin
        idle_found = 1'b1;
        idle_v     = voice_t'(i);
      end
      if (vstate_q[i] == RELEASING && (!rel_found || age_q[i] > rel_age)) begin
        rel_found = 1'b1;
        rel_v     = voice_t'(i);
        rel_age   = age_q[i];
      end
      if (vstate_q[i] == ACTIVE && age_q[i] >= act_age) begin
        act_v   = voice_t'(i);
        act_age = age_q[i];
      end
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    vstate_d   = vstate_q;
    vnote_d    = vnote_q;
    age_d      = age_q;
    victim_d   = victim_q;
    notes_d    = notes_q;
    strobe_d   = '0;
    overflow_d = bus.note_ready && q_full;
    q_pop      = 1'b0;
    go_steal   = 1'b0;
    touch_en   = 1'b0;
    touch_v    = '0;

    // Release first so a same-cycle assignment below overrides it.
    for (int i = 0; i < PIPELINE_COUNT; i++) begin
      if (vstate_q[i] == RELEASING && bus.pipeline_released[i]) vstate_d[i] = IDLE;
    end

    case (fsm_q)
      FSM_DECIDE: begin
        if (!q_empty) begin
          if (head.status == ON) begin
            if (match_found) begin
              notes_d[match_v]  = head;
              strobe_d[match_v] = 1'b1;
              touch_en          = 1'b1;
              touch_v           = match_v;
              q_pop             = 1'b1;
            end else if (idle_found) begin
              notes_d[idle_v]   = head;
              strobe_d[idle_v]  = 1'b1;
              vstate_d[idle_v]  = ACTIVE;
              vnote_d[idle_v]   = head.note_number;
              touch_en          = 1'b1;
              touch_v           = idle_v;
              q_pop             = 1'b1;
            end else begin
              victim_d           = rel_found ? rel_v : act_v;
              notes_d[victim_d]  = '{status: OFF, note_number: vnote_q[victim_d], velocity: '0};
              strobe_d[victim_d] = 1'b1;
              go_steal           = 1'b1;
            end
          end else begin
            if (match_found) begin
              notes_d[match_v]  = head;
              strobe_d[match_v] = 1'b1;
              vstate_d[match_v] = RELEASING;
            end
            q_pop = 1'b1;
          end
        end
      end
      FSM_STEAL: begin
        notes_d[victim_q]  = head;
        strobe_d[victim_q] = 1'b1;
        vstate_d[victim_q] = ACTIVE;
        vnote_d[victim_q]  = head.note_number;
        touch_en           = 1'b1;
        touch_v            = victim_q;
        q_pop              = 1'b1;
      end
      default: ;
    endcase

    if (touch_en) begin
      for (int i = 0; i < PIPELINE_COUNT; i++) begin
        if (age_q[i] < age_q[touch_v]) age_d[i] = age_q[i] + voice_t'(1);
      end
      age_d[touch_v] = '0;
    end

    next_count = q_count + CW'(push_acc) - CW'(q_pop);
    fsm_d      = go_steal ? FSM_STEAL : ((next_count != '0) ? FSM_DECIDE : FSM_IDLE);
  end

  always_ff @(posedge clock_50_000_000) begin
    if (!reset_l) begin
      fsm_q      <= FSM_IDLE;
      victim_q   <= '0;
      notes_q    <= '0;
      strobe_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < PIPELINE_COUNT; i++) begin
        vstate_q[i] <= IDLE;
        vnote_q[i]  <= '0;
        age_q[i]    <= voice_t'(i);
      end
    end else begin
      fsm_q      <= fsm_d;
      victim_q   <= victim_d;
      notes_q    <= notes_d;
      strobe_q   <= strobe_d;
      overflow_q <= overflow_d;
      vstate_q   <= vstate_d;
      vnote_q    <= vnote_d;
      age_q      <= age_d;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: event-queue/LRU-list reference model checked every cycle,
// plus directed scenarios with literal expected commands.
module tb_voice_scheduler;
  import voice_scheduler_pkg::*;

  localparam int P  = 4;
  localparam int QD = 8;
  localparam int V_IDLE = 0;
  localparam int V_ACT  = 1;
  localparam int V_REL  = 2;

  logic clk = 1'b0;
  logic reset_l;
  always #10 clk = ~clk;

  voice_scheduler_if #(.PIPELINE_COUNT(P)) bus ();

  voice_scheduler #(.PIPELINE_COUNT(P), .QUEUE_DEPTH(QD)) dut (
    .clock_50_000_000 (clk),
    .reset_l          (reset_l),
    .bus              (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ovf_seen = 0;
  bit run_checks = 1'b0;

  // Reference model: pending events, per-voice state/note, and recency list (front = newest).
  note_change_t          mq[$];
  int                    vst   [P];
  int                    vnote [P];
  int                    lru[$];
  bit                    stealing;
  int                    victim;
  note_change_t [P-1:0]  exp_notes;
  logic [P-1:0]          exp_strobe;
  logic                  exp_ovf;

  function automatic note_change_t mk(input status_t s, input int n, input int v);
    note_change_t r;
    r.status      = s;
    r.note_number = 7'(n);
    r.velocity    = 7'(v);
    return r;
  endfunction

  function void model_reset();
    mq.delete();
    lru.delete();
    for (int i = 0; i < P; i++) begin
      vst[i]   = V_IDLE;
      vnote[i] = 0;
      lru.push_back(i);
    end
    stealing   = 1'b0;
    victim     = 0;
    exp_notes  = '0;
    exp_strobe = '0;
    exp_ovf    = 1'b0;
  endfunction

  function void touch(input int v);
    for (int i = 0; i < lru.size(); i++) begin
      if (lru[i] == v) begin
        lru.delete(i);
        break;
      end
    end
    lru.push_front(v);
  endfunction

  function void cmd(input int v, input note_change_t n);
    exp_notes[v]  = n;
    exp_strobe[v] = 1'b1;
  endfunction

  function void model_step();
    int old_vst [P];
    int assigned, match, idle_v, vic;
    bit full;
    note_change_t h;
    old_vst  = vst;
    assigned = -1;
    match    = -1;
    idle_v   = -1;
    vic      = -1;
    full     = (mq.size() == QD);
    exp_strobe = '0;
    if (stealing) begin
      h = mq.pop_front();
      cmd(victim, h);
      vst[victim]   = V_ACT;
      vnote[victim] = int'(h.note_number);
      touch(victim);
      assigned = victim;
      stealing = 1'b0;
    end else if (mq.size() != 0) begin
      h = mq[0];
      for (int i = P - 1; i >= 0; i--) begin
        if (old_vst[i] == V_ACT && vnote[i] == int'(h.note_number)) match = i;
        if (old_vst[i] == V_IDLE) idle_v = i;
      end
      if (h.status == ON) begin
        if (match >= 0) begin
          cmd(match, h);
          touch(match);
          assigned = match;
          void'(mq.pop_front());
        end else if (idle_v >= 0) begin
          cmd(idle_v, h);
          vst[idle_v]   = V_ACT;
          vnote[idle_v] = int'(h.note_number);
          touch(idle_v);
          assigned = idle_v;
          void'(mq.pop_front());
        end else begin
          for (int k = lru.size() - 1; k >= 0 && vic < 0; k--)
            if (old_vst[lru[k]] == V_REL) vic = lru[k];
          if (vic < 0) vic = lru[lru.size() - 1];
          cmd(vic, mk(OFF, vnote[vic], 0));
          victim   = vic;
          stealing = 1'b1;
        end
      end else begin
        if (match >= 0) begin
          cmd(match, h);
          vst[match] = V_REL;
        end
        void'(mq.pop_front());
      end
    end
    for (int i = 0; i < P; i++)
      if (old_vst[i] == V_REL && bus.pipeline_released[i] && i != assigned) vst[i] = V_IDLE;
    exp_ovf = bus.note_ready && full;
    if (bus.note_ready && !full) mq.push_back(bus.note);
  endfunction

  always @(posedge clk) begin
    if (!reset_l) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin
    if (run_checks) begin
      checks++;
      if (bus.pipeline_notes !== exp_notes || bus.pipeline_notes_ready !== exp_strobe ||
          bus.overflow !== exp_ovf) begin
        failures++;
        $display("FAIL model_compare t=%0t got notes=%h rdy=%b ovf=%b expected notes=%h rdy=%b ovf=%b",
                 $time, bus.pipeline_notes, bus.pipeline_notes_ready, bus.overflow,
                 exp_notes, exp_strobe, exp_ovf);
      end
      checks++;
      if ($countones(bus.pipeline_notes_ready) > 1) begin
        failures++;
        $display("FAIL one_strobe t=%0t got rdy=%b expected at most one bit", $time,
                 bus.pipeline_notes_ready);
      end
      if (bus.overflow === 1'b1) ovf_seen++;
    end
  end

  // v >= 0: check that voice's command; v == -1: all commands zero; v == -2: commands not checked.
  task automatic check_lit(input string name, input logic [P-1:0] rdy, input int v,
                           input note_change_t n);
    bit bad;
    bad = (bus.pipeline_notes_ready !== rdy) || (bus.overflow !== 1'b0);
    if (v >= 0 && bus.pipeline_notes[v] !== n) bad = 1'b1;
    if (v == -1 && bus.pipeline_notes !== '0) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s got rdy=%b notes=%h ovf=%b expected rdy=%b voice=%0d cmd=%h ovf=0",
               name, bus.pipeline_notes_ready, bus.pipeline_notes, bus.overflow, rdy, v, n);
    end
  endtask

  task automatic ev(input status_t s, input int n, input int v);
    bus.note       = mk(s, n, v);
    bus.note_ready = 1'b1;
    @(negedge clk);
    bus.note_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.note_ready = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_l               = 1'b0;
    bus.note_ready        = 1'b0;
    bus.pipeline_released = '0;
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic fill_pool(input int v);
    ev(ON, 60, v); ev(ON, 62, v); ev(ON, 64, v); ev(ON, 65, v);
  endtask

  initial begin
    logic [P-1:0] r;
    model_reset();
    reset_l               = 1'b0;
    bus.note              = '0;
    bus.note_ready        = 1'b0;
    bus.pipeline_released = '0;
    repeat (3) @(negedge clk);
    run_checks = 1'b1;
    check_lit("reset_state", '0, -1, '0);
    reset_l = 1'b1;

    // First note lands on voice 0 two cycles after acceptance.
    ev(ON, 60, 100);
    idle(1);
    check_lit("first_on", 4'b0001, 0, mk(ON, 60, 100));
    idle(3);

    // Fifth distinct note steals the oldest active voice 0.
    do_reset();
    fill_pool(50);
    ev(ON, 67, 50);
    idle(1);
    check_lit("steal_off", 4'b0001, 0, mk(OFF, 60, 0));
    idle(1);
    check_lit("steal_on", 4'b0001, 0, mk(ON, 67, 50));
    idle(4);

    // Releasing voice is preferred as victim over older active voices.
    do_reset();
    fill_pool(40);
    ev(OFF, 62, 20);
    ev(ON, 70, 77);
    check_lit("key_off", 4'b0010, 1, mk(OFF, 62, 20));
    idle(1);
    check_lit("rel_victim_off", 4'b0010, 1, mk(OFF, 62, 0));
    idle(1);
    check_lit("rel_victim_on", 4'b0010, 1, mk(ON, 70, 77));
    idle(4);

    // Finished release frees the voice: plain assignment, no OFF.
    do_reset();
    fill_pool(40);
    ev(OFF, 62, 20);
    idle(1);
    check_lit("key_off_b", 4'b0010, 1, mk(OFF, 62, 20));
    bus.pipeline_released = 4'b0010;
    @(negedge clk);
    bus.pipeline_released = '0;
    ev(ON, 70, 77);
    check_lit("no_off_strobe", '0, -2, '0);
    idle(1);
    check_lit("freed_assign", 4'b0010, 1, mk(ON, 70, 77));
    idle(4);

    // Unmatched OFF is silent; repeated ON retriggers the same voice.
    do_reset();
    ev(OFF, 50, 0);
    idle(1);
    check_lit("off_unmatched", '0, -1, '0);
    ev(ON, 60, 10);
    ev(ON, 60, 90);
    check_lit("retrig_first", 4'b0001, 0, mk(ON, 60, 10));
    idle(1);
    check_lit("retrig_second", 4'b0001, 0, mk(ON, 60, 90));
    idle(4);

    // 20 back-to-back steals: queue fills, then every other event is dropped (events 14,16,18).
    do_reset();
    fill_pool(30);
    idle(3);
    ovf_seen = 0;
    for (int k = 0; k < 20; k++) ev(ON, 80 + k, 33);
    idle(60);
    checks++;
    if (ovf_seen != 3) begin
      failures++;
      $display("FAIL overflow_count got %0d pulses expected 3", ovf_seen);
    end

    // Reset between the OFF and ON halves of a steal.
    do_reset();
    fill_pool(30);
    idle(3);
    ev(ON, 70, 5);
    idle(1);
    check_lit("pre_reset_off", 4'b0001, 0, mk(OFF, 60, 0));
    reset_l = 1'b0;
    @(negedge clk);
    check_lit("reset_mid_steal", '0, -1, '0);
    reset_l = 1'b1;
    ev(ON, 61, 7);
    idle(1);
    check_lit("after_reset_on", 4'b0001, 0, mk(ON, 61, 7));
    idle(4);

    // Random traffic with occasional releases and resets.
    do_reset();
    repeat (3000) begin
      reset_l        = ($urandom_range(0, 799) != 0);
      bus.note_ready = ($urandom_range(0, 99) < 55);
      bus.note       = mk(($urandom_range(0, 9) < 7) ? ON : OFF,
                          60 + int'($urandom_range(0, 7)), int'($urandom_range(0, 127)));
      for (int b = 0; b < P; b++) r[b] = ($urandom_range(0, 5) == 0);
      bus.pipeline_released = r;
      @(negedge clk);
    end
    reset_l               = 1'b1;
    bus.pipeline_released = '0;
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
